// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched: LANES shared S-boxes time-multiplexed between a 16-byte SubBytes job and a 4-byte SubWord job, one beat per cycle.
// Latency 16/LANES (SubBytes) or ceil(4/LANES) (SubWord) plus one per lost contended beat; start ignored and kw_ready low while busy. Define AES_SBOX_SCHED_STATS_EN for stall_cnt.
module aes_sbox_sched #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_ready,
  output logic         kw_valid,
  output logic [31:0]  kw_out
`ifdef AES_SBOX_SCHED_STATS_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  localparam int SB_BEATS = 16 / LANES;
  localparam int KW_BEATS = (4 + LANES - 1) / LANES;
  localparam int KW_LANES = (LANES >= 4) ? 4 : LANES;
  localparam logic [3:0] SB_LAST = 4'(SB_BEATS - 1);
  localparam logic [3:0] KW_LAST = 4'(KW_BEATS - 1);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'(8 * (255 - int'(x))) +: 8];
  endfunction

  function automatic int byte_idx(input logic [3:0] cnt, input int lane, input int nbytes);
    return (int'(cnt) * LANES + lane) % nbytes;
  endfunction

  logic [127:0] sb_work, sb_nxt;
  logic [31:0]  kw_work, kw_nxt;
  logic [3:0]   sb_cnt, kw_cnt;
  logic         sb_busy, kw_busy, prio_kw;
  logic         contend, grant_kw, grant_sb, sb_fin, kw_fin;
  logic [7:0]   lane_in  [LANES];
  logic [7:0]   lane_out [LANES];

  always_comb begin
    contend  = sb_busy && kw_busy;
    grant_kw = kw_busy && (!sb_busy || prio_kw);
    grant_sb = sb_busy && !grant_kw;
    sb_nxt   = sb_work;
    kw_nxt   = kw_work;
    for (int l = 0; l < LANES; l++) begin
      // A SubWord beat owns lanes 0..3 exclusively; the upper lanes sit idle.
      lane_in[l]  = (grant_kw && l < KW_LANES) ? kw_work[5'(8 * byte_idx(kw_cnt, l, 4)) +: 8]
                                               : sb_work[7'(8 * byte_idx(sb_cnt, l, 16)) +: 8];
      lane_out[l] = sbox(lane_in[l]);
      if (grant_sb)
        sb_nxt[7'(8 * byte_idx(sb_cnt, l, 16)) +: 8] = lane_out[l];
      if (grant_kw && l < KW_LANES)
        kw_nxt[5'(8 * byte_idx(kw_cnt, l, 4)) +: 8] = lane_out[l];
    end
    sb_fin = grant_sb && (sb_cnt == SB_LAST);
    kw_fin = grant_kw && (kw_cnt == KW_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_work  <= '0;
      kw_work  <= '0;
      sb_cnt   <= '0;
      kw_cnt   <= '0;
      sb_busy  <= 1'b0;
      kw_busy  <= 1'b0;
      prio_kw  <= 1'b1;
      done     <= 1'b0;
      kw_valid <= 1'b0;
    end else begin
      done     <= sb_fin;
      kw_valid <= kw_fin;
      if (contend)
        prio_kw <= !grant_kw;
      if (start && !sb_busy) begin
        sb_work <= state_in;
        sb_cnt  <= '0;
        sb_busy <= 1'b1;
      end else if (grant_sb) begin
        sb_work <= sb_nxt;
        sb_cnt  <= sb_cnt + 4'd1;
        if (sb_fin)
          sb_busy <= 1'b0;
      end
      if (kw_req && !kw_busy) begin
        kw_work <= kw_in;
        kw_cnt  <= '0;
        kw_busy <= 1'b1;
      end else if (grant_kw) begin
        kw_work <= kw_nxt;
        kw_cnt  <= kw_cnt + 4'd1;
        if (kw_fin)
          kw_busy <= 1'b0;
      end
    end
  end

`ifdef AES_SBOX_SCHED_STATS_EN
  // Exactly one job loses the lanes on every contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (contend && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  assign busy      = sb_busy;
  assign kw_ready  = !kw_busy;
  assign state_out = sb_work;
  assign kw_out    = kw_work;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed bench for aes_sbox_sched: three instances (LANES 4, 1, 16) share one stimulus stream.
// Index 0 is LANES=4, index 1 is LANES=1, index 2 is LANES=16.
module tb_aes_sbox_sched;

  logic         clk = 1'b0;
  logic         rst_n, start, kw_req;
  logic [127:0] state_in;
  logic [31:0]  kw_in;
  logic [2:0]   busy_w, done_w, kw_ready_w, kw_valid_w;
  logic [127:0] so_w [3];
  logic [31:0]  ko_w [3];
`ifdef AES_SBOX_SCHED_STATS_EN
  logic [15:0]  st_w [3];
`endif

  always #5 clk = ~clk;

  aes_sbox_sched #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
    .busy(busy_w[0]), .done(done_w[0]), .state_out(so_w[0]),
    .kw_req(kw_req), .kw_in(kw_in), .kw_ready(kw_ready_w[0]),
    .kw_valid(kw_valid_w[0]), .kw_out(ko_w[0])
`ifdef AES_SBOX_SCHED_STATS_EN
    , .stall_cnt(st_w[0])
`endif
  );

  aes_sbox_sched #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
    .busy(busy_w[1]), .done(done_w[1]), .state_out(so_w[1]),
    .kw_req(kw_req), .kw_in(kw_in), .kw_ready(kw_ready_w[1]),
    .kw_valid(kw_valid_w[1]), .kw_out(ko_w[1])
`ifdef AES_SBOX_SCHED_STATS_EN
    , .stall_cnt(st_w[1])
`endif
  );

  aes_sbox_sched #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
    .busy(busy_w[2]), .done(done_w[2]), .state_out(so_w[2]),
    .kw_req(kw_req), .kw_in(kw_in), .kw_ready(kw_ready_w[2]),
    .kw_valid(kw_valid_w[2]), .kw_out(ko_w[2])
`ifdef AES_SBOX_SCHED_STATS_EN
    , .stall_cnt(st_w[2])
`endif
  );

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [31:0]  KW_IN    = 32'hcf4f3c09;
  localparam logic [31:0]  KW_OUT   = 32'h8a84eb01;
  localparam int SB_LAT [3] = '{4, 16, 1};
  localparam int KW_LAT [3] = '{1, 4, 1};

  int passed = 0;
  int total  = 0;

  int           done_at [3];
  int           kv_at [3];
  int           done_cnt [3];
  int           kr_low [3];
  logic [127:0] sb_res [3];
  logic [31:0]  kw_res [3];
  vec_t         vecs [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_reset(input int i, input string tag);
    check($sformatf("%s_busy_u%0d", tag, i), 128'(busy_w[i]), 128'd0);
    check($sformatf("%s_done_u%0d", tag, i), 128'(done_w[i]), 128'd0);
    check($sformatf("%s_kw_valid_u%0d", tag, i), 128'(kw_valid_w[i]), 128'd0);
    check($sformatf("%s_kw_ready_u%0d", tag, i), 128'(kw_ready_w[i]), 128'd1);
    check($sformatf("%s_state_out_u%0d", tag, i), so_w[i], 128'd0);
    check($sformatf("%s_kw_out_u%0d", tag, i), 128'(ko_w[i]), 128'd0);
`ifdef AES_SBOX_SCHED_STATS_EN
    check($sformatf("%s_stall_u%0d", tag, i), 128'(st_w[i]), 128'd0);
`endif
  endtask

  // Caller drives the request just after an edge; the next edge is the accepting edge (cycle 0).
  task automatic run_cycles(input int n, input int pulse_at, input logic [127:0] pulse_dat, input int rst_at);
    for (int i = 0; i < 3; i++) begin
      done_at[i] = -1; kv_at[i] = -1; done_cnt[i] = 0; kr_low[i] = 0;
      sb_res[i] = '0; kw_res[i] = '0;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      if (!kw_ready_w[i]) kr_low[i]++;
    start  = 1'b0;
    kw_req = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (done_w[i]) begin
          done_cnt[i]++;
          if (done_at[i] < 0) begin done_at[i] = c; sb_res[i] = so_w[i]; end
        end
        if (kw_valid_w[i] && kv_at[i] < 0) begin kv_at[i] = c; kw_res[i] = ko_w[i]; end
        if (!kw_ready_w[i]) kr_low[i]++;
      end
      start = (c == pulse_at);
      if (c == pulse_at) state_in = pulse_dat;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_reset(0, "midrst");
      end
      if (c == rst_at + 2) rst_n = 1'b1;
    end
  endtask

  initial begin
    vecs[0] = '{din: FIPS_IN, dout: FIPS_OUT};
    vecs[1] = '{din: 128'h0f0e0d0c0b0a09080706050403020100,
                dout: 128'h76abd7fe2b670130c56f6bf27b777c63};
    vecs[2] = '{din: {16{8'h00}}, dout: {16{8'h63}}};
    vecs[3] = '{din: {16{8'h53}}, dout: {16{8'hed}}};

    rst_n = 1'b0; start = 1'b0; kw_req = 1'b0; state_in = '0; kw_in = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_reset(i, "init");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      state_in = vecs[v].din;
      start    = 1'b1;
      run_cycles(24, -1, '0, -1);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("sb_lat_v%0d_u%0d", v, i), 128'(done_at[i]), 128'(SB_LAT[i]));
        check($sformatf("sb_dat_v%0d_u%0d", v, i), sb_res[i], vecs[v].dout);
        check($sformatf("sb_pulses_v%0d_u%0d", v, i), 128'(done_cnt[i]), 128'd1);
      end
    end

    kw_in  = KW_IN;
    kw_req = 1'b1;
    run_cycles(8, -1, '0, -1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("kw_lat_u%0d", i), 128'(kv_at[i]), 128'(KW_LAT[i]));
      check($sformatf("kw_dat_u%0d", i), 128'(kw_res[i]), 128'(KW_OUT));
      check($sformatf("kw_ready_low_u%0d", i), 128'(kr_low[i]), 128'(KW_LAT[i]));
    end

    // Both requests on one edge; SubWord wins the first contended beat.
    state_in = FIPS_IN;
    start    = 1'b1;
    kw_req   = 1'b1;
    run_cycles(24, -1, '0, -1);
    check("cont_kw_lat_u0", 128'(kv_at[0]), 128'd1);
    check("cont_kw_lat_u1", 128'(kv_at[1]), 128'd7);
    check("cont_kw_lat_u2", 128'(kv_at[2]), 128'd1);
    check("cont_sb_lat_u0", 128'(done_at[0]), 128'd5);
    check("cont_sb_lat_u1", 128'(done_at[1]), 128'd20);
    check("cont_sb_lat_u2", 128'(done_at[2]), 128'd2);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cont_sb_dat_u%0d", i), sb_res[i], FIPS_OUT);
      check($sformatf("cont_kw_dat_u%0d", i), 128'(kw_res[i]), 128'(KW_OUT));
    end
`ifdef AES_SBOX_SCHED_STATS_EN
    check("cont_stall_u0", 128'(st_w[0]), 128'd1);
    check("cont_stall_u1", 128'(st_w[1]), 128'd7);
    check("cont_stall_u2", 128'(st_w[2]), 128'd1);
`endif

    // start held high: each new job is accepted on the edge closing the done cycle.
    state_in = '0;
    start    = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_done_c%0d", c), 128'(done_w[0]), 128'((c % 5) == 4));
      if ((c % 5) == 4) check($sformatf("b2b_dat_c%0d", c), so_w[0], {16{8'h63}});
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    state_in = {16{8'h53}};
    start    = 1'b1;
    run_cycles(10, 2, FIPS_IN, -1);
    check("ign_lat_u0", 128'(done_at[0]), 128'd4);
    check("ign_dat_u0", sb_res[0], {16{8'hed}});
    check("ign_pulses_u0", 128'(done_cnt[0]), 128'd1);
    repeat (20) @(posedge clk);
    #1;

    state_in = FIPS_IN;
    start    = 1'b1;
    run_cycles(8, -1, '0, 2);
    check("rst_no_done_u0", 128'(done_cnt[0]), 128'd0);
    check("rst_no_done_u1", 128'(done_cnt[1]), 128'd0);
    state_in = {16{8'h53}};
    start    = 1'b1;
    run_cycles(24, -1, '0, -1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post_rst_lat_u%0d", i), 128'(done_at[i]), 128'(SB_LAT[i]));
      check($sformatf("post_rst_dat_u%0d", i), sb_res[i], {16{8'hed}});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
